// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Program sequencer for the CPU's 9-bit instruction port. A
//               host loads up to DEPTH words into a small buffer, sets a
//               program length and pulses start; the block then issues one
//               word per clock (stretched by stall). It reports busy, a
//               one-cycle done pulse, and a sticky error on an illegal opcode.
// Ports       : clk          CPU clock, rising edge
//               rst_n        synchronous active-low reset
//               wr_en        write wr_data into buffer[wr_addr] this cycle
//               wr_addr      buffer write address
//               wr_data      9-bit instruction word to store
//               prog_len     words to issue (0..DEPTH, larger is clamped),
//                            sampled with start
//               start        begin a run from address 0 (honoured in idle only)
//               stall        hold the word currently on instruction
//               instruction  word driven to the CPU (NOP when not valid)
//               instr_valid  instruction carries a program word
//               pc           buffer address of the word on instruction
//               busy         a program word is being issued
//               done         one-cycle pulse after the last word
//               error        sticky illegal-opcode flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [8:0]    wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stall,
    output logic [8:0]    instruction,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [8:0]  C_NOP   = 9'b111000000;
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0] C_ONE   = (AW + 1)'(1);

    // S_LAUNCH is the one-cycle gap between an accepted start and the first
    // word appearing on the output; it is the cycle in which buffer word 0 is
    // read, which is what lets a same-cycle write to address 0 take effect.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_len;
    logic [8:0]    r_mem [DEPTH];

    logic [AW:0]   w_len_clamped;
    logic [AW-1:0] w_next_idx;
    logic [8:0]    w_next_word;
    logic          w_next_legal;
    logic          w_last;
    logic          w_advance;

    // ------------------------------------------------------------------------
    // Program buffer: plain synchronous-write storage, never reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Next-word fetch. In S_LAUNCH pc already holds 0, so the first word is
    // buffer[0]; in S_RUN it is the word after the one on the output. The
    // wrap of pc+1 at DEPTH-1 is harmless because that index is only reached
    // when the run is finishing.
    // ------------------------------------------------------------------------
    always_comb begin
        w_len_clamped = (prog_len > C_DEPTH) ? C_DEPTH : prog_len;
        w_next_idx    = (r_state == S_LAUNCH) ? pc : pc + 1'b1;
        w_next_word   = r_mem[w_next_idx];
        w_last        = ({1'b0, pc} == (r_len - C_ONE));
        w_advance     = (r_state == S_LAUNCH) || ((r_state == S_RUN) && !stall);

        case (w_next_word[8:6])
            3'b000, 3'b011, 3'b100, 3'b110: w_next_legal = 1'b1;
            default:                        w_next_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM with all outputs registered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            instruction <= C_NOP;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (w_len_clamped == '0) begin
                            // Empty program: report completion straight away.
                            done <= 1'b1;
                        end else begin
                            r_len   <= w_len_clamped;
                            pc      <= '0;
                            r_state <= S_LAUNCH;
                        end
                    end
                end

                S_LAUNCH, S_RUN: begin
                    if (w_advance) begin
                        if ((r_state == S_RUN) && w_last) begin
                            r_state     <= S_DONE;
                            instruction <= C_NOP;
                            instr_valid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else if (!w_next_legal) begin
                            // Abort: the illegal word is never driven.
                            r_state     <= S_IDLE;
                            instruction <= C_NOP;
                            instr_valid <= 1'b0;
                            busy        <= 1'b0;
                            error       <= 1'b1;
                            pc          <= w_next_idx;
                        end else begin
                            r_state     <= S_RUN;
                            instruction <= w_next_word;
                            instr_valid <= 1'b1;
                            busy        <= 1'b1;
                            pc          <= w_next_idx;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer. A bench-side copy of
//               the program is used to predict, cycle by cycle, which words
//               are issued, for how long, and how each run ends.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int         DEPTH = 16;
    localparam int         AW    = 4;
    localparam logic [8:0] NOP   = 9'b111000000;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          stall;
    logic [8:0]    instruction;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          error;

    int tests;
    int fails;
    int done_seen;

    logic [8:0] prog [DEPTH];

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .prog_len    (prog_len),
        .start       (start),
        .stall       (stall),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen = done_seen + 1;
    end

    function automatic bit is_legal(input logic [8:0] w);
        return (w[8:6] == 3'b000) || (w[8:6] == 3'b011) ||
               (w[8:6] == 3'b100) || (w[8:6] == 3'b110);
    endfunction

    function automatic logic [8:0] rand_word(input bit allow_illegal);
        logic [2:0] ops [4];
        logic [8:0] w;
        ops[0] = 3'b000; ops[1] = 3'b011; ops[2] = 3'b100; ops[3] = 3'b110;
        w = 9'($urandom);
        if (!(allow_illegal && ($urandom_range(0, 9) == 0)))
            w[8:6] = ops[$urandom_range(0, 3)];
        return w;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic load_word(input int addr, input logic [8:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
        prog[addr] = data;
    endtask

    task automatic load_plan_program();
        logic [8:0] plan [8];
        plan[0] = 9'h01E; plan[1] = 9'h03F; plan[2] = 9'h180; plan[3] = 9'h0CA;
        plan[4] = 9'h0E5; plan[5] = 9'h100; plan[6] = 9'h0D4; plan[7] = 9'h0F9;
        for (int i = 0; i < 8; i++) load_word(i, plan[i]);
    endtask

    // Start a run and check every cycle until the block is idle again.
    // mode: 0 no stall, 1 random stalls, 2 three stall cycles on word 2.
    task automatic run_program(input int len_in, input int mode, input bit mid_start,
                               input bit wr0, input logic [8:0] w0,
                               output int busy_cycles);
        int  eff;
        int  nissue;
        int  extra;
        bit  exp_err;
        busy_cycles = 0;
        if (wr0) prog[0] = w0;
        eff     = (len_in > DEPTH) ? DEPTH : len_in;
        nissue  = eff;
        exp_err = 1'b0;
        for (int i = 0; i < eff; i++) begin
            if (!is_legal(prog[i])) begin
                nissue  = i;
                exp_err = 1'b1;
                break;
            end
        end

        prog_len = (AW + 1)'(len_in);
        start    = 1'b1;
        stall    = 1'b0;
        if (wr0) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = w0;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;

        tests++;
        if (instruction !== NOP || instr_valid !== 1'b0 || busy !== 1'b0 ||
            error !== 1'b0 || done !== (eff == 0)) begin
            fails++;
            $display("FAIL start_cycle len=%0d: instr=%h valid=%b busy=%b err=%b done=%b, want instr=%h valid=0 busy=0 err=0 done=%0d",
                     len_in, instruction, instr_valid, busy, error, done, NOP, (eff == 0));
        end

        if (eff == 0) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || busy !== 1'b0 || instruction !== NOP) begin
                fails++;
                $display("FAIL empty_after: done=%b busy=%b instr=%h, want done=0 busy=0 instr=%h",
                         done, busy, instruction, NOP);
            end
            return;
        end

        @(negedge clk);
        for (int k = 0; k < nissue; k++) begin
            if (mode == 1)      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            else if (mode == 2) extra = (k == 2) ? 3 : 0;
            else                extra = 0;
            for (int h = 0; h <= extra; h++) begin
                tests++;
                if (instruction !== prog[k] || instr_valid !== 1'b1 || pc !== AW'(k) ||
                    busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
                    fails++;
                    $display("FAIL word k=%0d hold=%0d: instr=%h valid=%b pc=%0d busy=%b done=%b err=%b, want instr=%h valid=1 pc=%0d busy=1 done=0 err=0",
                             k, h, instruction, instr_valid, pc, busy, done, error, prog[k], k);
                end
                busy_cycles++;
                stall = (h < extra);
                start = (mid_start && k == 1 && h == 0);
                @(negedge clk);
            end
        end
        stall = 1'b0;
        start = 1'b0;

        tests++;
        if (instruction !== NOP || instr_valid !== 1'b0 || busy !== 1'b0 ||
            done !== !exp_err || error !== exp_err) begin
            fails++;
            $display("FAIL run_end len=%0d: instr=%h valid=%b busy=%b done=%b err=%b, want instr=%h valid=0 busy=0 done=%0d err=%0d",
                     len_in, instruction, instr_valid, busy, done, error, NOP, !exp_err, exp_err);
        end
        // A start arriving while done is showing must be ignored.
        start    = mid_start;
        prog_len = 5'd8;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (instruction !== NOP || busy !== 1'b0 || done !== 1'b0 || error !== exp_err) begin
            fails++;
            $display("FAIL after_end: instr=%h busy=%b done=%b err=%b, want instr=%h busy=0 done=0 err=%0d",
                     instruction, busy, done, error, NOP, exp_err);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL stays_idle: busy=%b valid=%b, want busy=0 valid=0", busy, instr_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (instruction !== NOP || instr_valid !== 1'b0 || pc !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL reset: instr=%h valid=%b pc=%0d busy=%b done=%b err=%b, want %h 0 0 0 0 0",
                     instruction, instr_valid, pc, busy, done, error, NOP);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_program();
        int bc;
        load_plan_program();
        run_program(8, 0, 1'b0, 1'b0, 9'h000, bc);
        tests++;
        if (bc != 8) begin
            fails++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
    endtask

    task automatic test_stall();
        int bc;
        load_plan_program();
        run_program(8, 2, 1'b0, 1'b0, 9'h000, bc);
        tests++;
        if (bc != 11) begin
            fails++;
            $display("FAIL stall_run_length: got %0d, want 11", bc);
        end
    endtask

    task automatic test_zero_len();
        int bc;
        run_program(0, 0, 1'b0, 1'b0, 9'h000, bc);
    endtask

    task automatic test_illegal();
        int bc;
        load_plan_program();
        load_word(3, 9'h1C0);
        run_program(8, 0, 1'b0, 1'b0, 9'h000, bc);
        repeat (3) @(negedge clk);
        tests++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL error_sticky: err=%b busy=%b, want err=1 busy=0", error, busy);
        end
        load_word(3, 9'h0CA);
        run_program(8, 0, 1'b0, 1'b0, 9'h000, bc);
    endtask

    task automatic test_reset_mid_run();
        int  bc;
        bit  hit;
        load_plan_program();
        prog_len = 5'd8;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1 && pc === 4'd4) begin
                hit = 1'b1;
                break;
            end
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL reach_pc4: pc=%0d valid=%b, want pc=4 valid=1 within 20 cycles", pc, instr_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (instruction !== NOP || busy !== 1'b0 || pc !== '0 || instr_valid !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run: instr=%h busy=%b pc=%0d valid=%b done=%b, want %h 0 0 0 0",
                     instruction, busy, pc, instr_valid, done, NOP);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_program(8, 0, 1'b0, 1'b0, 9'h000, bc);
    endtask

    task automatic test_start_during_run();
        int bc;
        int d0;
        load_plan_program();
        d0 = done_seen;
        run_program(8, 0, 1'b1, 1'b0, 9'h000, bc);
        repeat (2) @(negedge clk);
        tests++;
        if (done_seen - d0 != 1) begin
            fails++;
            $display("FAIL single_done: got %0d done pulses, want 1", done_seen - d0);
        end
    endtask

    task automatic test_write_start_same_cycle();
        int bc;
        load_plan_program();
        run_program(8, 0, 1'b0, 1'b1, 9'h155, bc);
    endtask

    task automatic test_clamp();
        int bc;
        for (int i = 0; i < DEPTH; i++) load_word(i, rand_word(1'b0));
        run_program(27, 1, 1'b0, 1'b0, 9'h000, bc);
    endtask

    task automatic test_random();
        int bc;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < DEPTH; i++) load_word(i, rand_word(1'b1));
            run_program($urandom_range(0, 20), 1, 1'b0, 1'b0, 9'h000, bc);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        done_seen = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        prog_len  = '0;
        start     = 1'b0;
        stall     = 1'b0;
        for (int i = 0; i < DEPTH; i++) prog[i] = NOP;
        @(negedge clk);

        test_reset();
        test_basic_program();
        test_stall();
        test_zero_len();
        test_illegal();
        test_reset_mid_run();
        test_start_during_run();
        test_write_start_same_cycle();
        test_clamp();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
